reg_scoreboard: RTL and testbench

- Parametrised register-busy scoreboard for the pipelined CPU.
- Internally decodes an ADDR_W-bit destination address into a one-hot set mask, and an ADDR_W-bit write-back address into a one-hot clear mask.
- Keeps one busy bit per architectural register and stalls issue on RAW/WAW hazards.
- Generalises the fixed 5-to-32 write-enable decode to any width, with state, hazard lookup and occupancy tracking.

---
 rtl/reg_scoreboard.sv | 115 +++++++++++
 tb/tb_reg_scoreboard.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register busy tracking with RAW/WAW issue stall.
// One busy bit per architectural register; set on issue of a writing
// instruction, cleared on write-back. The hard-wired zero register is
// never tracked and never stalls.
// Optional build macro: SCOREBOARD_WB_BYPASS_EN -- when defined, a
// same-cycle write-back frees its register for the hazard lookup.

module reg_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREG     = 32,
  parameter int unsigned ZERO_REG = 31
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                issue_valid,
  input  logic                issue_wr,
  input  logic [ADDR_W-1:0]   issue_dst,
  input  logic [ADDR_W-1:0]   issue_rs1,
  input  logic [ADDR_W-1:0]   issue_rs2,
  output logic                stall,
  input  logic                wb_valid,
  input  logic [ADDR_W-1:0]   wb_addr,
  output logic [NREG-1:0]     busy_vec,
  output logic [ADDR_W:0]     pending_count,
  output logic                wb_err
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  // One-hot decode of a register address into an NREG-wide mask.
  function automatic logic [NREG-1:0] dec(input logic [ADDR_W-1:0] a);
    logic [NREG-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      m[i] = (ADDR_W'(i) == a);
    end
    return m;
  endfunction

  logic [NREG-1:0]  clr_mask;
  logic [NREG-1:0]  set_mask;
  logic [NREG-1:0]  busy_eff;
  logic [NREG-1:0]  busy_next;
  logic [CNT_W-1:0] count_next;
  logic             fire;
  logic             rs1_hit;
  logic             rs2_hit;
  logic             dst_hit;
  logic             wb_bad;

  // Write-back clear mask; a clear of a non-busy register is harmless.
  always_comb begin
    clr_mask = '0;
    if (wb_valid) begin
      clr_mask = dec(wb_addr);
    end
  end

  // Busy view used for hazard lookup.
  always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
    busy_eff = busy_vec & ~clr_mask;
`else
    busy_eff = busy_vec;
`endif
  end

  // Hazard lookup and issue stall; zero register bit is always clear so it never hits.
  always_comb begin
    rs1_hit = busy_eff[issue_rs1];
    rs2_hit = busy_eff[issue_rs2];
    dst_hit = issue_wr & busy_eff[issue_dst];
    stall   = issue_valid & (rs1_hit | rs2_hit | dst_hit);
    fire    = issue_valid & ~stall;
  end

  // Issue set mask; writes to the zero register are not tracked.
  always_comb begin
    set_mask = '0;
    if (fire && issue_wr && (issue_dst != ZERO_ADDR)) begin
      set_mask = dec(issue_dst);
    end
  end

  // Next busy state (set wins over clear) and its population count.
  always_comb begin
    busy_next  = (busy_vec & ~clr_mask) | set_mask;
    count_next = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      count_next = count_next + CNT_W'(busy_next[i]);
    end
  end

  // Write-back error: target not busy in the registered state, or the zero register.
  always_comb begin
    wb_bad = wb_valid & (~busy_vec[wb_addr] | (wb_addr == ZERO_ADDR));
  end

  // State registers: busy bits, occupancy count and sticky error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec      <= '0;
      pending_count <= '0;
      wb_err        <= 1'b0;
    end else begin
      busy_vec      <= busy_next;
      pending_count <= count_next;
      if (wb_bad) begin
        wb_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard with hand-computed expectations.
// Build with +define+SCOREBOARD_WB_BYPASS_EN to check the bypass variant.

module tb_reg_scoreboard;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned NREG   = 32;

  logic              clk;
  logic              reset;
  logic              issue_valid;
  logic              issue_wr;
  logic [ADDR_W-1:0] issue_dst;
  logic [ADDR_W-1:0] issue_rs1;
  logic [ADDR_W-1:0] issue_rs2;
  logic              stall;
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [NREG-1:0]   busy_vec;
  logic [ADDR_W:0]   pending_count;
  logic              wb_err;

  int n_checks;
  int n_fail;

  reg_scoreboard #(.ADDR_W(ADDR_W), .NREG(NREG), .ZERO_REG(31)) dut (
    .clk           (clk),
    .reset         (reset),
    .issue_valid   (issue_valid),
    .issue_wr      (issue_wr),
    .issue_dst     (issue_dst),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .stall         (stall),
    .wb_valid      (wb_valid),
    .wb_addr       (wb_addr),
    .busy_vec      (busy_vec),
    .pending_count (pending_count),
    .wb_err        (wb_err)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Apply a full input vector, then let combinational outputs settle.
  task automatic drive(input logic iv, input logic wr, input logic [4:0] dst,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic wv, input logic [4:0] wa);
    issue_valid = iv;
    issue_wr    = wr;
    issue_dst   = dst;
    issue_rs1   = rs1;
    issue_rs2   = rs2;
    wb_valid    = wv;
    wb_addr     = wa;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd31, 5'd31, 5'd31, 1'b0, 5'd0);
  endtask

  // Advance one rising edge and sample 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    idle();
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", busy_vec, 32'h0);
    check("rst_count", 32'(pending_count), 32'd0);
    check("rst_err", 32'(wb_err), 32'd0);
    check("rst_stall_idle", 32'(stall), 32'd0);

    // Issue dst=3: no stall, busy from next cycle.
    drive(1'b1, 1'b1, 5'd3, 5'd0, 5'd1, 1'b0, 5'd0);
    check("issue3_stall", 32'(stall), 32'd0);
    tick();
    check("issue3_busy", busy_vec, 32'h0000_0008);
    check("issue3_count", 32'(pending_count), 32'd1);

    // RAW on r3, then write-back of r3.
    drive(1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0);
    check("raw3_stall", 32'(stall), 32'd1);
    drive(1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b1, 5'd3);
`ifdef SCOREBOARD_WB_BYPASS_EN
    check("raw3_wb_stall", 32'(stall), 32'd0);
`else
    check("raw3_wb_stall", 32'(stall), 32'd1);
`endif
    tick();
    drive(1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 1'b0, 5'd0);
    check("raw3_after_stall", 32'(stall), 32'd0);
    check("wb3_busy", busy_vec, 32'h0);
    check("wb3_count", 32'(pending_count), 32'd0);
    check("wb3_err", 32'(wb_err), 32'd0);

    // Write to zero register is not tracked; write-back to it flags an error.
    drive(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 5'd0);
    check("dst31_stall", 32'(stall), 32'd0);
    tick();
    check("dst31_busy", busy_vec, 32'h0);
    check("dst31_count", 32'(pending_count), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd31);
    tick();
    check("wb31_err", 32'(wb_err), 32'd1);
    idle();
    tick();
    tick();
    check("wb31_err_sticky", 32'(wb_err), 32'd1);

    // Fill every trackable register.
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b1, 5'(i), 5'd31, 5'd31, 1'b0, 5'd0);
      if (i == 0 || i == 15 || i == 30) begin
        check($sformatf("fill%0d_stall", i), 32'(stall), 32'd0);
      end
      tick();
    end
    check("full_busy", busy_vec, 32'h7FFF_FFFF);
    check("full_count", 32'(pending_count), 32'd31);
    drive(1'b1, 1'b0, 5'd0, 5'd31, 5'd31, 1'b0, 5'd0);
    check("full_zero_src_stall", 32'(stall), 32'd0);
    drive(1'b1, 1'b1, 5'd31, 5'd31, 5'd31, 1'b0, 5'd0);
    check("full_zero_dst_stall", 32'(stall), 32'd0);
    drive(1'b1, 1'b0, 5'd0, 5'd31, 5'd10, 1'b0, 5'd0);
    check("full_rs2_stall", 32'(stall), 32'd1);
    drive(1'b1, 1'b1, 5'd4, 5'd31, 5'd31, 1'b0, 5'd0);
    check("full_waw_stall", 32'(stall), 32'd1);
    drive(1'b0, 1'b1, 5'd4, 5'd10, 5'd12, 1'b0, 5'd0);
    check("full_novalid_stall", 32'(stall), 32'd0);

    // Free r5, then issue r5 while writing back r7 in the same edge.
    drive(1'b0, 1'b0, 5'd0, 5'd31, 5'd31, 1'b1, 5'd5);
    tick();
    check("free5_busy", busy_vec, 32'h7FFF_FFDF);
    check("free5_count", 32'(pending_count), 32'd30);
    drive(1'b1, 1'b1, 5'd5, 5'd31, 5'd31, 1'b1, 5'd7);
    check("swap_stall", 32'(stall), 32'd0);
    tick();
    check("swap_busy", busy_vec, 32'h7FFF_FF7F);
    check("swap_count", 32'(pending_count), 32'd30);

    // Issue writing r8 while r8 is written back.
    drive(1'b1, 1'b1, 5'd8, 5'd31, 5'd31, 1'b1, 5'd8);
`ifdef SCOREBOARD_WB_BYPASS_EN
    check("setclr8_stall", 32'(stall), 32'd0);
    tick();
    check("setclr8_busy", busy_vec, 32'h7FFF_FF7F);
    check("setclr8_count", 32'(pending_count), 32'd30);
`else
    check("setclr8_stall", 32'(stall), 32'd1);
    tick();
    check("setclr8_busy", busy_vec, 32'h7FFF_FE7F);
    check("setclr8_count", 32'(pending_count), 32'd29);
`endif

    // Reset overrides concurrent issue and write-back.
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd20, 5'd31, 5'd31, 1'b1, 5'd3);
    tick();
    reset = 1'b0;
    idle();
    check("midrst_busy", busy_vec, 32'h0);
    check("midrst_count", 32'(pending_count), 32'd0);
    check("midrst_err", 32'(wb_err), 32'd0);
    drive(1'b1, 1'b1, 5'd2, 5'd9, 5'd17, 1'b0, 5'd0);
    check("empty_stall", 32'(stall), 32'd0);
    idle();

    // Write-back of a register that is not busy.
    drive(1'b0, 1'b0, 5'd0, 5'd31, 5'd31, 1'b1, 5'd9);
    tick();
    idle();
    check("wb_notbusy_err", 32'(wb_err), 32'd1);
    check("wb_notbusy_busy", busy_vec, 32'h0);
    check("wb_notbusy_count", 32'(pending_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
